// File: rtl/bus_arb_if.sv
// Bus-source handshake bundle for the datapath bus arbiter: requests and final-cycle
// flags in, one-hot grant and tri-state enables out.
interface bus_arb_if #(
   parameter int N     = 4,
   parameter int IDX_W = 2
);
   logic [N-1:0]     req;
   logic [N-1:0]     last;
   logic [N-1:0]     gnt;
   logic [N-1:0]     gate_en;
   logic             busy;
   logic [IDX_W-1:0] owner;
   logic             preempt;

   // The arbiter owns the grant side; the bus sources own the request side.
   modport master (
      input  req,
      input  last,
      output gnt,
      output gate_en,
      output busy,
      output owner,
      output preempt
   );

   modport slave (
      output req,
      output last,
      input  gnt,
      input  gate_en,
      input  busy,
      input  owner,
      input  preempt
   );
endinterface

// File: rtl/bus_arb.sv
// Round-robin arbiter and gate sequencer for the shared tri-state datapath bus.
// Break-before-make: every ownership is followed by one cycle with no gate enabled.
module bus_arb #(
   parameter int N        = 4,
   parameter int IDX_W    = 2,
   parameter int HOLD_MAX = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   bus_arb_if.master  bus
);

   typedef enum logic {
      IDLE,
      OWN
   } state_t;

   localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);
   localparam logic       HOLD_EN  = (HOLD_MAX != 0);

   state_t           state;
   logic [N-1:0]     gnt_q;
   logic [N-1:0]     gate_q;
   logic             busy_q;
   logic [IDX_W-1:0] owner_q;
   logic [IDX_W-1:0] rr_ptr;
   logic [3:0]       hold_cnt;
   logic             preempt_q;

   logic             found;
   logic [IDX_W-1:0] sel;
   logic [IDX_W:0]   scan;
   logic [N-1:0]     sel_onehot;

   logic             req_own;
   logic             last_own;
   logic             end_done;
   logic             end_abandon;
   logic             end_forced;
   logic             end_any;
   logic [IDX_W-1:0] next_ptr;

   // Scan from rr_ptr upward, wrapping at N; the first requester found wins.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      scan  = '0;
      for (int i = 0; i < N; i++) begin
         scan = {1'b0, rr_ptr} + (IDX_W+1)'(i);
         if (scan >= (IDX_W+1)'(N)) begin
            scan = scan - (IDX_W+1)'(N);
         end
         if (!found && bus.req[scan[IDX_W-1:0]]) begin
            found = 1'b1;
            sel   = scan[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      sel_onehot      = '0;
      sel_onehot[sel] = 1'b1;
   end

   assign req_own     = bus.req[owner_q];
   assign last_own    = bus.last[owner_q];
   assign end_done    = req_own & last_own;
   assign end_abandon = ~req_own;
   assign end_forced  = HOLD_EN & (hold_cnt == HOLD_LIM);
   assign end_any     = end_done | end_abandon | end_forced;
   assign next_ptr    = (owner_q == IDX_W'(N-1)) ? '0 : owner_q + IDX_W'(1);

   // preempt only flags a revoke the owner did not ask for.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         gnt_q     <= '0;
         gate_q    <= '0;
         busy_q    <= 1'b0;
         owner_q   <= '0;
         rr_ptr    <= '0;
         hold_cnt  <= '0;
         preempt_q <= 1'b0;
      end else begin
         preempt_q <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  state    <= OWN;
                  gnt_q    <= sel_onehot;
                  gate_q   <= sel_onehot;
                  busy_q   <= 1'b1;
                  owner_q  <= sel;
                  hold_cnt <= 4'd1;
               end
            end
            OWN: begin
               if (end_any) begin
                  state     <= IDLE;
                  gnt_q     <= '0;
                  gate_q    <= '0;
                  busy_q    <= 1'b0;
                  rr_ptr    <= next_ptr;
                  preempt_q <= end_forced & ~end_done & ~end_abandon;
               end else if (hold_cnt != 4'hF) begin
                  hold_cnt <= hold_cnt + 4'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.gate_en = gate_q;
   assign bus.busy    = busy_q;
   assign bus.owner   = owner_q;
   assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_bus_arb.sv
// Scoreboard bench for bus_arb: two instances (hold limit 8 and unlimited) share stimulus
// and are compared against a cycle-level reference model of the arbitration rules.
module tb_bus_arb;
   localparam int N     = 4;
   localparam int IDX_W = 2;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   bus_arb_if #(.N(N), .IDX_W(IDX_W)) bus_a ();
   bus_arb_if #(.N(N), .IDX_W(IDX_W)) bus_b ();

   bus_arb #(.N(N), .IDX_W(IDX_W), .HOLD_MAX(8)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   bus_arb #(.N(N), .IDX_W(IDX_W), .HOLD_MAX(0)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   typedef struct {
      bit own;
      int owner;
      int ptr;
      int cnt;
      bit pre;
   } mstate_t;

   typedef struct {
      mstate_t a;
      mstate_t b;
   } exp_t;

   exp_t    exp_q[$];
   exp_t    e;
   mstate_t ma;
   mstate_t mb;
   int      errors = 0;
   int      checks = 0;

   // Reference: who owns the bus after this edge, given the inputs seen at it.
   function automatic mstate_t modelStep(mstate_t s, logic [N-1:0] rq, logic [N-1:0] ls,
                                         logic rstn, int hmax);
      mstate_t n;
      bit      done_a, done_b, done_c, picked;
      int      cand;
      n     = s;
      n.pre = 1'b0;
      if (!rstn) begin
         n.own   = 1'b0;
         n.owner = 0;
         n.ptr   = 0;
         n.cnt   = 0;
         return n;
      end
      if (!s.own) begin
         picked = 1'b0;
         for (int k = 0; k < N; k++) begin
            cand = (s.ptr + k) % N;
            if (!picked && rq[cand[IDX_W-1:0]]) begin
               picked  = 1'b1;
               n.own   = 1'b1;
               n.owner = cand;
               n.cnt   = 1;
            end
         end
      end else begin
         done_a = rq[s.owner[IDX_W-1:0]] && ls[s.owner[IDX_W-1:0]];
         done_b = !rq[s.owner[IDX_W-1:0]];
         done_c = (hmax != 0) && (s.cnt == hmax);
         if (done_a || done_b || done_c) begin
            n.own = 1'b0;
            n.ptr = (s.owner + 1) % N;
            n.pre = done_c && !done_a && !done_b;
         end else begin
            n.cnt = s.cnt + 1;
         end
      end
      return n;
   endfunction

   function automatic logic [31:0] expGnt(mstate_t s);
      return s.own ? (32'd1 << s.owner) : 32'd0;
   endfunction

   task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: actual=%0h expected=%0h", name, $time, actual, expected);
      end
   endtask

   task automatic applyStimulus(logic [N-1:0] rq, logic [N-1:0] ls, logic rstn);
      exp_t x;
      @(negedge clk);
      bus_a.req  = rq;
      bus_a.last = ls;
      bus_b.req  = rq;
      bus_b.last = ls;
      rst_n      = rstn;
      ma         = modelStep(ma, rq, ls, rstn, 8);
      mb         = modelStep(mb, rq, ls, rstn, 0);
      x.a        = ma;
      x.b        = mb;
      exp_q.push_back(x);
   endtask

   // Monitor: each edge's outcome is checked just after the edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checkOutput("gnt_a",     32'(bus_a.gnt),     expGnt(e.a));
         checkOutput("gate_en_a", 32'(bus_a.gate_en), expGnt(e.a));
         checkOutput("busy_a",    32'(bus_a.busy),    32'(e.a.own));
         checkOutput("owner_a",   32'(bus_a.owner),   32'(e.a.owner));
         checkOutput("preempt_a", 32'(bus_a.preempt), 32'(e.a.pre));
         checkOutput("gnt_b",     32'(bus_b.gnt),     expGnt(e.b));
         checkOutput("gate_en_b", 32'(bus_b.gate_en), expGnt(e.b));
         checkOutput("busy_b",    32'(bus_b.busy),    32'(e.b.own));
         checkOutput("owner_b",   32'(bus_b.owner),   32'(e.b.owner));
         checkOutput("preempt_b", 32'(bus_b.preempt), 32'(e.b.pre));
      end
   end

   initial begin
      logic [N-1:0] rq;
      logic [N-1:0] ls;
      logic         rs;
      rst_n      = 1'b0;
      bus_a.req  = '0;
      bus_a.last = '0;
      bus_b.req  = '0;
      bus_b.last = '0;
      ma         = '{own: 1'b0, owner: 0, ptr: 0, cnt: 0, pre: 1'b0};
      mb         = ma;

      repeat (2) applyStimulus(4'b0000, 4'b0000, 1'b0);

      $display("[TB] single request with final cycle");
      repeat (4) applyStimulus(4'b0100, 4'b0000, 1'b1);
      applyStimulus(4'b0100, 4'b0100, 1'b1);
      repeat (2) applyStimulus(4'b0000, 4'b0000, 1'b1);

      $display("[TB] all requesting, round-robin rotation");
      repeat (12) applyStimulus(4'b1111, 4'b1111, 1'b1);
      repeat (2) applyStimulus(4'b0000, 4'b0000, 1'b1);

      $display("[TB] hold limit revoke");
      repeat (12) applyStimulus(4'b0010, 4'b0000, 1'b1);
      repeat (12) applyStimulus(4'b0011, 4'b0000, 1'b1);
      repeat (2) applyStimulus(4'b0000, 4'b0000, 1'b1);

      $display("[TB] owner 3 abandons with others pending");
      repeat (2) applyStimulus(4'b1000, 4'b0000, 1'b1);
      applyStimulus(4'b1101, 4'b0000, 1'b1);
      repeat (3) applyStimulus(4'b0101, 4'b0000, 1'b1);
      repeat (2) applyStimulus(4'b0000, 4'b0000, 1'b1);

      $display("[TB] reset during ownership");
      repeat (5) applyStimulus(4'b0010, 4'b0000, 1'b1);
      applyStimulus(4'b0010, 4'b0000, 1'b0);
      repeat (3) applyStimulus(4'b0010, 4'b0000, 1'b1);
      repeat (2) applyStimulus(4'b0000, 4'b0000, 1'b1);

      $display("[TB] long hold, unlimited vs limited");
      repeat (40) applyStimulus(4'b0001, 4'b0000, 1'b1);
      repeat (2) applyStimulus(4'b0000, 4'b0000, 1'b1);

      $display("[TB] randomized traffic");
      rq = '0;
      for (int c = 0; c < 400; c++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
            ls[b] = ($urandom_range(0, 3) == 0);
         end
         rs = ($urandom_range(0, 59) != 0);
         applyStimulus(rq, ls, rs);
      end
      repeat (3) applyStimulus(4'b0000, 4'b0000, 1'b1);

      @(posedge clk);
      #2;
      checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
